// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB master bridge and its timeout counter.
package apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    localparam int unsigned APB_MST_TIMEOUT_DEFAULT = 256;

    // A disabled timeout still needs a 1-bit counter to keep the port list uniform.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Core-side request port and APB3 master signals of the bridge, bundled together.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  req_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic                  pwrite_o;
    logic                  psel_o;
    logic                  penable_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  req_i, addr_i, we_i, wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport slave (
        output req_i, addr_i, we_i, wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

endinterface

// File: rtl/apb_master_bridge_timeout_cnt.sv
// Wait-state counter for the ACCESS phase; flags the last allowed cycle.
module apb_timeout_cnt
    import apb_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned   CW   = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at LAST so a stuck enable can never wrap back to a non-expired value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Converts a req/gnt/rvalid core port into APB3 transfers, with a hang-proof access timeout.
//   state  | meaning
//   IDLE   | no transfer; grant follows req
//   SETUP  | psel asserted, address/data phase
//   ACCESS | psel+penable, waiting for pready or timeout
module apb_master_bridge
    import apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_DEFAULT
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_master_bridge_if.master bus
);

    apb_mst_state_e r_state;
    apb_mst_state_e w_next_state;

    logic                  w_gnt;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_expired;
    logic                  w_cnt_en;
    logic                  w_done_ok;
    logic                  w_done_tmo;

    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    // pready takes priority over a timeout landing in the same cycle.
    assign w_done_ok  = (r_state == ACCESS) && bus.pready_i;
    assign w_done_tmo = (r_state == ACCESS) && !bus.pready_i && w_expired;
    assign w_cnt_en   = (r_state == ACCESS) && !bus.pready_i;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .i_clr     (w_gnt),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_i) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (w_done_ok || w_done_tmo) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt     = 1'b0;
        w_psel    = 1'b0;
        w_penable = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt = bus.req_i;
            end
            SETUP: begin
                w_psel = 1'b1;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default: begin
                w_gnt = 1'b0;
            end
        endcase
    end

    // Request fields are captured only on grant, so they stay frozen for the whole transfer.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_gnt) begin
                r_paddr  <= bus.addr_i;
                r_pwdata <= bus.wdata_i;
                r_pwrite <= bus.we_i;
            end
            if (w_done_ok) begin
                r_rvalid <= 1'b1;
                r_err    <= bus.pslverr_i;
                r_rdata  <= r_pwrite ? '0 : bus.prdata_i;
            end else if (w_done_tmo) begin
                r_rvalid <= 1'b1;
                r_err    <= 1'b1;
                r_rdata  <= '0;
            end
        end
    end

    assign bus.gnt_o     = w_gnt;
    assign bus.psel_o    = w_psel;
    assign bus.penable_o = w_penable;
    assign bus.paddr_o   = r_paddr;
    assign bus.pwdata_o  = r_pwdata;
    assign bus.pwrite_o  = r_pwrite;
    assign bus.rvalid_o  = r_rvalid;
    assign bus.rdata_o   = r_rdata;
    assign bus.err_o     = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: a per-cycle transfer schedule is built up front and compared to the bridge every cycle.
module tb_apb_master_bridge;

    localparam int TO   = 8;
    localparam int NCYC = 4000;

    logic HCLK = 1'b0;
    logic HRESETn;

    apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    bit        s_req[NCYC], s_we[NCYC], s_pready[NCYC], s_pslverr[NCYC], s_rstn[NCYC];
    bit [31:0] s_addr[NCYC], s_wdata[NCYC], s_prdata[NCYC];

    bit        e_gnt[NCYC], e_psel[NCYC], e_pen[NCYC], e_rvalid[NCYC], e_err[NCYC], e_pwrite[NCYC];
    bit [31:0] e_rdata[NCYC], e_paddr[NCYC], e_pwdata[NCYC];

    bit        ev_clr[NCYC], ev_rsp[NCYC], ev_pa[NCYC], ev_err[NCYC], ev_pwrite[NCYC];
    bit [31:0] ev_rdata[NCYC], ev_paddr[NCYC], ev_pwdata[NCYC];

    typedef struct {
        int          c;
        int          sig;
        logic [31:0] val;
    } pin_t;
    pin_t pins[$];

    int idle_from;
    int prev_g;
    int n_end = 0;
    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    function automatic string sig_name(int s);
        case (s)
            0: return "gnt";
            1: return "psel";
            2: return "penable";
            3: return "rvalid";
            4: return "rdata";
            5: return "err";
            6: return "paddr";
            7: return "pwdata";
            default: return "pwrite";
        endcase
    endfunction

    function automatic logic [31:0] dut_sig(int s);
        case (s)
            0: return 32'(bus.gnt_o);
            1: return 32'(bus.psel_o);
            2: return 32'(bus.penable_o);
            3: return 32'(bus.rvalid_o);
            4: return bus.rdata_o;
            5: return 32'(bus.err_o);
            6: return bus.paddr_o;
            7: return bus.pwdata_o;
            default: return 32'(bus.pwrite_o);
        endcase
    endfunction

    function automatic logic [31:0] exp_sig(int s, int c);
        case (s)
            0: return 32'(e_gnt[c]);
            1: return 32'(e_psel[c]);
            2: return 32'(e_pen[c]);
            3: return 32'(e_rvalid[c]);
            4: return e_rdata[c];
            5: return 32'(e_err[c]);
            6: return e_paddr[c];
            7: return e_pwdata[c];
            default: return 32'(e_pwrite[c]);
        endcase
    endfunction

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
        end
    endtask

    task automatic pin(int c, int s, logic [31:0] v);
        pins.push_back('{c, s, v});
    endtask

    // One transfer: request starts in cycle r and is held until granted; w wait states before
    // pready, or abort by reset in access cycle rst_k (rst_k < 0 means no reset).
    task automatic add_xfer(int r, bit we, bit [31:0] addr, bit [31:0] wdata, int w,
                            bit [31:0] prdata, bit slverr, int rst_k);
        int g, kd, v;
        bit tmo;
        g   = (r > idle_from) ? r : idle_from;
        tmo = (w > TO - 1);
        kd  = tmo ? TO - 1 : w;
        for (int c = r; c <= g; c++) begin
            s_req[c]   = 1'b1;
            s_addr[c]  = addr;
            s_we[c]    = we;
            s_wdata[c] = wdata;
        end
        e_gnt[g]       = 1'b1;
        ev_pa[g+1]     = 1'b1;
        ev_paddr[g+1]  = addr;
        ev_pwdata[g+1] = wdata;
        ev_pwrite[g+1] = we;
        if (rst_k >= 0) begin
            for (int k = 0; k <= rst_k; k++) s_pready[g+2+k] = 1'b0;
            s_rstn[g+2+rst_k] = 1'b0;
            for (int c = g + 1; c <= g + 2 + rst_k; c++) e_psel[c] = 1'b1;
            for (int c = g + 2; c <= g + 2 + rst_k; c++) e_pen[c] = 1'b1;
            ev_clr[g+3+rst_k] = 1'b1;
            idle_from = g + 3 + rst_k;
            prev_g    = idle_from - 1;
        end else begin
            for (int k = 0; k <= kd; k++) s_pready[g+2+k] = 1'b0;
            if (!tmo) begin
                s_pready[g+2+kd]  = 1'b1;
                s_pslverr[g+2+kd] = slverr;
                s_prdata[g+2+kd]  = prdata;
            end
            for (int c = g + 1; c <= g + 2 + kd; c++) e_psel[c] = 1'b1;
            for (int c = g + 2; c <= g + 2 + kd; c++) e_pen[c] = 1'b1;
            v = g + 3 + kd;
            e_rvalid[v] = 1'b1;
            ev_rsp[v]   = 1'b1;
            ev_rdata[v] = (tmo || we) ? 32'h0 : prdata;
            ev_err[v]   = tmo ? 1'b1 : slverr;
            idle_from   = v;
            prev_g      = g;
        end
    endtask

    task automatic build();
        bit [31:0] cur_rdata, cur_paddr, cur_pwdata;
        bit        cur_err, cur_pwrite;
        int        r, w, rk, kd;
        for (int c = 0; c < NCYC; c++) begin
            s_req[c]     = 1'b0;
            s_rstn[c]    = 1'b1;
            s_addr[c]    = $urandom;
            s_wdata[c]   = $urandom;
            s_prdata[c]  = $urandom;
            s_we[c]      = 1'($urandom_range(0, 1));
            s_pready[c]  = 1'($urandom_range(0, 1));
            s_pslverr[c] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 3; c++) s_rstn[c] = 1'b0;
        ev_clr[1] = 1'b1;
        idle_from = 3;
        prev_g    = 2;

        add_xfer(5,  1'b1, 32'h1A10_0004, 32'hCAFE_F00D, 0,   32'h0,         1'b0, -1);
        add_xfer(10, 1'b0, 32'h1A10_2000, 32'h0,         3,   32'h1234_5678, 1'b0, -1);
        add_xfer(18, 1'b0, 32'h1A10_0100, 32'h0,         0,   32'hDEAD_BEEF, 1'b1, -1);
        add_xfer(22, 1'b0, 32'h1A10_0104, 32'h0,         0,   32'h0BAD_F00D, 1'b0, -1);
        add_xfer(27, 1'b0, 32'h1A10_0200, 32'h0,         100, 32'h0,         1'b0, -1);
        add_xfer(39, 1'b0, 32'h1A10_0204, 32'h0,         7,   32'h55AA_55AA, 1'b0, -1);
        add_xfer(51, 1'b1, 32'h1A10_0010, 32'h1111_2222, 0,   32'h0,         1'b0, -1);
        add_xfer(52, 1'b0, 32'h1A10_0014, 32'h0,         0,   32'h3333_4444, 1'b0, -1);
        add_xfer(58, 1'b0, 32'h1A10_3000, 32'h0,         20,  32'h0,         1'b0, 2);
        add_xfer(64, 1'b0, 32'h1A10_0008, 32'h0,         1,   32'hA5A5_0001, 1'b0, -1);

        pin(5, 0, 32'h1);  pin(6, 1, 32'h1);  pin(6, 2, 32'h0);  pin(7, 2, 32'h1);
        pin(8, 1, 32'h0);  pin(8, 3, 32'h1);  pin(8, 4, 32'h0);  pin(8, 5, 32'h0);
        pin(6, 6, 32'h1A10_0004); pin(7, 6, 32'h1A10_0004); pin(7, 7, 32'hCAFE_F00D);
        pin(12, 2, 32'h1); pin(15, 2, 32'h1); pin(16, 2, 32'h0); pin(15, 3, 32'h0);
        pin(16, 3, 32'h1); pin(16, 4, 32'h1234_5678);
        pin(21, 5, 32'h1); pin(21, 4, 32'hDEAD_BEEF);
        pin(25, 5, 32'h0); pin(25, 4, 32'h0BAD_F00D);
        pin(36, 1, 32'h1); pin(37, 1, 32'h0); pin(37, 3, 32'h1); pin(37, 5, 32'h1); pin(37, 4, 32'h0);
        pin(48, 2, 32'h1); pin(49, 3, 32'h1); pin(49, 5, 32'h0); pin(49, 4, 32'h55AA_55AA);
        pin(53, 0, 32'h0); pin(54, 0, 32'h1); pin(54, 3, 32'h1); pin(57, 3, 32'h1);
        pin(57, 4, 32'h3333_4444); pin(55, 6, 32'h1A10_0014);
        pin(62, 2, 32'h1); pin(63, 1, 32'h0); pin(63, 2, 32'h0); pin(63, 3, 32'h0); pin(63, 6, 32'h0);
        pin(68, 3, 32'h1); pin(68, 4, 32'hA5A5_0001); pin(68, 5, 32'h0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) r = prev_g + 1 + int'($urandom_range(0, 2));
            else                           r = idle_from + int'($urandom_range(0, 3));
            w  = int'($urandom_range(0, 10));
            kd = (w > TO - 1) ? TO - 1 : w;
            rk = -1;
            if (kd > 0 && $urandom_range(0, 19) == 0) rk = int'($urandom_range(0, kd - 1));
            add_xfer(r, 1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom,
                     1'($urandom_range(0, 1)), rk);
        end
        n_end = idle_from + 4;

        cur_rdata = '0; cur_paddr = '0; cur_pwdata = '0; cur_err = 1'b0; cur_pwrite = 1'b0;
        for (int c = 0; c < n_end; c++) begin
            if (ev_clr[c]) begin
                cur_rdata = '0; cur_paddr = '0; cur_pwdata = '0; cur_err = 1'b0; cur_pwrite = 1'b0;
            end
            if (ev_rsp[c]) begin
                cur_rdata = ev_rdata[c];
                cur_err   = ev_err[c];
            end
            if (ev_pa[c]) begin
                cur_paddr  = ev_paddr[c];
                cur_pwdata = ev_pwdata[c];
                cur_pwrite = ev_pwrite[c];
            end
            e_rdata[c]  = cur_rdata;
            e_err[c]    = cur_err;
            e_paddr[c]  = cur_paddr;
            e_pwdata[c] = cur_pwdata;
            e_pwrite[c] = cur_pwrite;
        end
    endtask

    task automatic apply(int c);
        HRESETn       = s_rstn[c];
        bus.req_i     = s_req[c];
        bus.addr_i    = s_addr[c];
        bus.we_i      = s_we[c];
        bus.wdata_i   = s_wdata[c];
        bus.prdata_i  = s_prdata[c];
        bus.pready_i  = s_pready[c];
        bus.pslverr_i = s_pslverr[c];
    endtask

    always @(negedge HCLK) begin
        if (cyc >= 3 && cyc < n_end) begin
            for (int s = 0; s < 9; s++) chk(sig_name(s), cyc, dut_sig(s), exp_sig(s, cyc));
            foreach (pins[i]) begin
                if (pins[i].c == cyc) chk({"pin_", sig_name(pins[i].sig)}, cyc, dut_sig(pins[i].sig), pins[i].val);
            end
        end
    end

    initial begin
        build();
        apply(0);
        while (cyc < n_end) begin
            @(posedge HCLK);
            cyc++;
            #1;
            apply(cyc);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Initiator end of the APB_BUS interface: converts a core-side req/gnt/rvalid memory-style port into APB3 transfers (psel/penable/pready/pslverr).
- Sits between a bus-domain initiator (debug unit or AXI-lite shim) and the APB_BUS master modport feeding the peripheral decoder.
- Adds a programmable-free hardware timeout so a hung peripheral can never stall the initiator forever.

Parameters:
- ADDR_WIDTH, 32, width of addr_i/paddr_o.
- DATA_WIDTH, 32, width of wdata/rdata/pwdata/prdata.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error termination; 0 disables the timeout.

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset; one clock; reset is synchronous and active-low.
- req_i  in  1  transfer request, held until granted.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  DATA_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o.
- err_o  out  1  pslverr or timeout, valid with rvalid_o.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pwrite_o  out  1  APB direction.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset (HRESETn=0 at a rising edge): state=IDLE; psel_o, penable_o, pwrite_o, rvalid_o, err_o = 0; paddr_o, pwdata_o, rdata_o = 0; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: gnt_o = req_i. On req_i, register addr_i→paddr_o, wdata_i→pwdata_o and we_i→pwrite_o, then go to SETUP.
  - SETUP: psel_o=1, penable_o=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: psel_o=1, penable_o=1. Counter increments each cycle pready_i=0.
    - If pready_i=1: go to IDLE; next cycle rvalid_o=1, err_o=pslverr_i, rdata_o = pwrite_o ? 0 : prdata_i.
    - If pready_i=0 and counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): go to IDLE; next cycle rvalid_o=1, err_o=1, rdata_o=0.
- gnt_o is 0 outside IDLE. Requests while busy wait, and req_i must be held.
- paddr_o, pwdata_o and pwrite_o are stable from SETUP through the end of ACCESS, and hold their last value in IDLE.
- psel_o and penable_o drop in the cycle after completion.
- rvalid_o is a single-cycle pulse. rdata_o and err_o hold until the next rvalid_o.
- Latency (req to rvalid) with zero wait states: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rvalid in cycle 3. Each wait state adds 1 cycle.
- Back-to-back: the rvalid_o cycle is an IDLE cycle, so a new req_i is granted in the same cycle. Throughput is 1 transfer per 3 cycles.
- pslverr_i is sampled only when pready_i=1 in ACCESS and is ignored otherwise.
- Timeout counter clears on every entry to SETUP. It is DATA-independent and sized $clog2(TIMEOUT_CYCLES+1).
- Timeout and pready_i in the same cycle: pready_i wins and err_o=pslverr_i.
- Reset mid-transfer: psel_o and penable_o are 0 on the next edge, no rvalid_o is issued, and the initiator must re-request.

Decomposition:
- Package apb_mst_pkg holds:
  - enum apb_mst_state_e {IDLE, SETUP, ACCESS};
  - localparam default TIMEOUT_CYCLES.
- Sub-module apb_timeout_cnt: counter with clear/enable/expired, parameterised on TIMEOUT_CYCLES; expired is tied to 0 when the parameter is 0.
- The FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write addr=0x1A10_0004, data=0xCAFE_F00D, pready=1 at once → psel rises cycle 1, penable cycle 2, rvalid cycle 3, err=0, rdata=0, paddr/pwdata stable cycles 1-2.
- Read addr=0x1A10_2000, pready after 3 wait states, prdata=0x1234_5678 → rvalid at cycle 6, rdata=0x1234_5678, penable high 4 cycles.
- Read with pready=1 and pslverr=1 → rvalid with err=1, rdata=prdata. Next transfer with pslverr=0 → err=0.
- pready held 0 with TIMEOUT_CYCLES=8 → after 8 ACCESS cycles psel drops; rvalid with err=1, rdata=0.
- Two queued requests (req held) → second gnt coincides with first rvalid; transfers 3 cycles apart, no psel gap violation.
- HRESETn=0 for 1 cycle during ACCESS → psel/penable 0 next edge, no rvalid, FSM IDLE; a fresh request then completes normally.
